// File: rtl/output_row_sequencer.sv
// Streams the N_SIZE rows of a result matrix downstream one at a time after a start pulse.
// Define OUT_BACKPRESSURE_EN to honour out_ready; otherwise every streaming cycle is a transfer.
module output_row_sequencer #(
  parameter int N_SIZE = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_in,
  input  logic                      out_ready,
  output logic [$clog2(N_SIZE)-1:0] sel,
  output logic                      valid_out,
  output logic                      last_out,
  output logic                      done,
  output logic                      busy,
  output logic                      overrun
);

  localparam int SEL_W = $clog2(N_SIZE);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_SIZE - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             xfer;
  logic             at_last;

`ifdef OUT_BACKPRESSURE_EN
  assign xfer = valid_q & out_ready;
`else
  // out_ready stays on the port for drop-in compatibility but has no effect here.
  logic unused_ready;
  assign unused_ready = out_ready;
  assign xfer = valid_q;
`endif

  assign at_last = (sel_q == LAST_SEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = STREAM;
      STREAM:  if (xfer && at_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Computes next values of the registered outputs; a start outside IDLE only latches the error.
  always_comb begin
    sel_d     = sel_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    busy_d    = (state_d != IDLE);
    overrun_d = overrun_q | (start_in && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        sel_d   = '0;
        valid_d = start_in;
      end
      STREAM: begin
        if (xfer) begin
          if (at_last) begin
            sel_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            sel_d = sel_q + SEL_ONE;
          end
        end
      end
      default: begin
        sel_d   = '0;
        valid_d = 1'b0;
      end
    endcase
    last_d = valid_d && (sel_d == LAST_SEL);
  end

  assign sel       = sel_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
